// File: rtl/xor_wrap_pkg.sv
// Shared definitions for the XOR key-wrap datapath: FSM states, default width
// and the zero-key constant used for zeroization.
package xor_wrap_pkg;

   localparam int unsigned WIDTH_DEF = 128;

   typedef enum logic [1:0] {
      NOKEY = 2'd0,
      ARMED = 2'd1,
      REKEY = 2'd2
   } state_t;

   localparam logic [WIDTH_DEF-1:0] ZERO_KEY = '0;

endpackage

// File: rtl/xor_unwrap_reader_zeroizing_fifo2.sv
// Two-entry FIFO whose storage is cleared on pop and wiped by a synchronous flush,
// so no recovered plaintext lingers after it has been consumed or zeroized.
module zeroizing_fifo2 #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             pop_ok, push_ok;

   assign count     = count_q;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   assign pop_ok  = pop && (count_q != 2'd0);
   assign push_ok = push && ((count_q < 2'd2) || pop_ok);

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_d[i] = '0;
         end
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         // Clear the popped slot first so a simultaneous push into the same
         // slot (full FIFO) keeps the new word.
         if (pop_ok) begin
            mem_d[rd_ptr_q] = '0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
         end
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/xor_unwrap_reader.sv
// Receive-side XOR key unwrap: wrapped words are XORed with the held key on
// acceptance and buffered in a zeroizing 2-entry FIFO. Rekeying waits for the
// FIFO to drain; key_clear wipes key, pending key and buffered data.
module xor_unwrap_reader
   import xor_wrap_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_wr,
   input  logic [WIDTH-1:0] key_in,
   input  logic             key_clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             key_loaded,
   output logic [CNT_W-1:0] word_cnt
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] key_q, key_d;
   logic [WIDTH-1:0] pending_key_q, pending_key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       fifo_count;
   logic             fifo_valid;
   logic             fifo_push;
   logic             fifo_pop;

   assign in_ready   = (state_q == ARMED) && (fifo_count < 2'd2);
   assign key_loaded = (state_q == ARMED);
   assign out_valid  = fifo_valid;
   assign word_cnt   = cnt_q;

   // A word accepted in the same cycle as key_clear is dropped by the flush.
   assign fifo_push = in_valid && in_ready && !key_clear;
   assign fifo_pop  = fifo_valid && out_ready;

   zeroizing_fifo2 #(
      .WIDTH(WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (key_clear),
      .push      (fifo_push),
      .push_data (in_data ^ key_q),
      .pop       (fifo_pop),
      .count     (fifo_count),
      .out_valid (fifo_valid),
      .out_data  (out_data)
   );

   // Key-state FSM, key registers and saturating delivered-word counter.
   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      pending_key_d = pending_key_q;
      cnt_d         = cnt_q;

      if (fifo_pop && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (key_clear) begin
         key_d         = WIDTH'(ZERO_KEY);
         pending_key_d = WIDTH'(ZERO_KEY);
         state_d       = NOKEY;
      end else begin
         case (state_q)
            NOKEY: begin
               if (key_wr) begin
                  key_d   = key_in;
                  state_d = ARMED;
               end
            end
            ARMED: begin
               if (key_wr) begin
                  pending_key_d = key_in;
                  state_d       = REKEY;
               end
            end
            REKEY: begin
               if (key_wr) begin
                  pending_key_d = key_in;
               end else if (fifo_count == 2'd0) begin
                  key_d   = pending_key_q;
                  state_d = ARMED;
               end
            end
            default: state_d = NOKEY;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= NOKEY;
         key_q         <= '0;
         pending_key_q <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         pending_key_q <= pending_key_d;
         cnt_q         <= cnt_d;
      end
   end

endmodule

// File: tb/tb_xor_unwrap_reader.sv
// Directed self-checking bench for xor_unwrap_reader with a reference
// model and an expected-output scoreboard queue.
module tb_xor_unwrap_reader;

   localparam int unsigned W = 128;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_wr, key_clear, in_valid, out_ready;
   logic [W-1:0] key_in, in_data;
   logic         in_ready, out_valid, key_loaded;
   logic [W-1:0] out_data;
   logic [15:0]  word_cnt;

   logic         s_key_wr, s_key_clear, s_in_valid, s_out_ready;
   logic [W-1:0] s_key_in, s_in_data;
   logic         s_in_ready, s_out_valid, s_key_loaded;
   logic [W-1:0] s_out_data;
   logic [3:0]   s_word_cnt;

   int checks = 0;
   int errors = 0;

   typedef enum int {M_NOKEY, M_ARMED, M_REKEY} mstate_t;
   mstate_t      st_m = M_NOKEY;
   logic [W-1:0] key_m = '0;
   logic [W-1:0] pend_m = '0;
   logic [15:0]  cnt_m = '0;
   logic [W-1:0] sb [$];

   always #5 clk = ~clk;

   xor_unwrap_reader #(.WIDTH(W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .key_wr(key_wr), .key_in(key_in), .key_clear(key_clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .key_loaded(key_loaded), .word_cnt(word_cnt)
   );

   xor_unwrap_reader #(.WIDTH(W), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .key_wr(s_key_wr), .key_in(s_key_in), .key_clear(s_key_clear),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .key_loaded(s_key_loaded), .word_cnt(s_word_cnt)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Check outputs against the model for this cycle, update the model from the
   // driven inputs, then advance one clock.
   task automatic tick();
      int unsigned  pre;
      logic [W-1:0] exp_w;
      pre = sb.size();
      chk("in_ready", in_ready, (st_m == M_ARMED) && (pre < 2));
      chk("out_valid", out_valid, pre != 0);
      chk("key_loaded", key_loaded, st_m == M_ARMED);
      chk("word_cnt", word_cnt, cnt_m);
      if (pre == 0) begin
         chk("out_data_idle", out_data, '0);
      end else if (out_ready) begin
         exp_w = sb.pop_front();
         chk("out_data", out_data, exp_w);
         if (cnt_m != 16'hFFFF) cnt_m++;
      end
      if (key_clear) begin
         sb.delete();
         key_m  = '0;
         pend_m = '0;
         st_m   = M_NOKEY;
      end else begin
         case (st_m)
            M_NOKEY: if (key_wr) begin key_m = key_in; st_m = M_ARMED; end
            M_ARMED: begin
               if (in_valid && pre < 2) sb.push_back(in_data ^ key_m);
               if (key_wr) begin pend_m = key_in; st_m = M_REKEY; end
            end
            default: begin
               if (key_wr) pend_m = key_in;
               else if (pre == 0) begin key_m = pend_m; st_m = M_ARMED; end
            end
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned  pops;
      logic [W-1:0] key_a, key_b;

      rst = 1'b0; key_wr = 1'b0; key_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      key_in = '0; in_data = '0;
      s_key_wr = 1'b0; s_key_clear = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
      s_key_in = '0; s_in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, '0);
      chk("rst_out_valid", out_valid, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_key_loaded", key_loaded, '0);
      chk("rst_word_cnt", word_cnt, '0);
      chk("rst_key", dut.key_q, '0);
      rst = 1'b1;

      // No key: input must be refused.
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = rnd();
         tick();
      end
      in_valid = 1'b0;

      // Load key 0F.., stream FF.. and 00..
      key_a = {16{8'h0F}};
      key_wr = 1'b1; key_in = key_a;
      tick();
      key_wr = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; in_data = '1;
      tick();
      in_data = '0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("cnt_two", word_cnt, 16'd2);

      // Backpressure: three offered, two accepted, then drain in order.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = rnd();
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_valid = 1'b0;
      tick();
      tick();

      // Rekey while two words under key A are buffered.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = rnd();
         tick();
      end
      in_valid = 1'b0;
      key_b = rnd();
      key_wr = 1'b1; key_in = key_b;
      tick();
      key_wr = 1'b0;
      in_valid = 1'b1; in_data = rnd();
      tick();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("rekey_key", dut.key_q, key_b);

      // key_clear with a full FIFO and a stalled consumer.
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = rnd();
         tick();
      end
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0; in_valid = 1'b0;
      chk("clr_out_valid", out_valid, '0);
      chk("clr_out_data", out_data, '0);
      chk("clr_key_loaded", key_loaded, '0);
      chk("clr_key", dut.key_q, '0);
      chk("clr_pend", dut.pending_key_q, '0);
      chk("clr_mem0", dut.u_fifo.mem_q[0], '0);
      chk("clr_mem1", dut.u_fifo.mem_q[1], '0);
      tick();
      tick();

      // Saturation on the 4-bit counter build.
      s_key_wr = 1'b1; s_key_in = rnd();
      @(posedge clk);
      #1;
      s_key_wr = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
      pops = 0;
      for (int i = 0; i < 25; i++) begin
         s_in_data = rnd();
         chk("sat_cnt", s_word_cnt, (pops > 15) ? 15 : pops);
         if (s_out_valid) pops++;
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      chk("sat_final", s_word_cnt, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
